// File: rtl/ms_serial_radix_mul.sv
// ms_serial_radix_mul
// Chained serial multiplier. It forms the product of NUM_INPUTS operands of
// DATA_WIDTH bits each. Each multiplier operand is scanned MSB-first,
// BITS_PER_CYCLE bits per enabled clock. Operands can be taken as unsigned
// or as two's complement: the datapath works on magnitudes and the sign is
// applied in a single FIX cycle at the end.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   en           global enable; every register holds while low
//   start        request, sampled only in IDLE with en=1
//   signed_mode  sampled with start; 1 = two's-complement operands/result
//   bin_data_in  operand array, sampled with start
//   bin_data_out registered product, held between operations
//   busy         high from the accept edge until the edge that raises done
//   done         one-enabled-cycle result strobe
module ms_serial_radix_mul #(
    parameter int DATA_WIDTH     = 5,
    parameter int NUM_INPUTS     = 2,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               start,
    input  logic                               signed_mode,
    input  logic [DATA_WIDTH-1:0]              bin_data_in [NUM_INPUTS-1:0],
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]   bin_data_out,
    output logic                               busy,
    output logic                               done
);

    localparam int PW   = NUM_INPUTS * DATA_WIDTH;
    localparam int DPS  = DATA_WIDTH / BITS_PER_CYCLE;
    // The multiplier queue holds operands 1..N-1. It keeps at least one
    // slot so that index 0 is always legal, even when NUM_INPUTS=1.
    localparam int OPS  = (NUM_INPUTS > 1) ? NUM_INPUTS - 1 : 1;
    localparam int MAGN = OPS + 1;
    localparam int DIGW = (DPS > 1) ? $clog2(DPS) : 1;
    localparam int JW   = $clog2(NUM_INPUTS + 1);

    if (DATA_WIDTH % BITS_PER_CYCLE != 0) begin : g_chk_div
        $error("DATA_WIDTH must be a multiple of BITS_PER_CYCLE");
    end
    if (NUM_INPUTS < 1) begin : g_chk_num
        $error("NUM_INPUTS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PW-1:0]         r_p;
    logic [PW-1:0]         r_acc;
    logic [PW-1:0]         r_out;
    logic [DATA_WIDTH-1:0] r_ops [OPS];
    logic [DIGW-1:0]       r_dig;
    logic [JW-1:0]         r_j;
    logic                  r_neg;
    logic                  r_busy;
    logic                  r_done;

    logic [DATA_WIDTH-1:0]     w_mag [MAGN];
    logic [NUM_INPUTS-1:0]     w_sgn;
    logic                      w_neg;
    logic [BITS_PER_CYCLE-1:0] w_digit;
    logic [PW-1:0]             w_acc_next;
    logic                      w_last_dig;
    logic                      w_last_stage;

    // Magnitude of each operand. In signed mode the most negative value
    // maps to 2^(DATA_WIDTH-1), which still fits as a DATA_WIDTH-bit
    // unsigned value.
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_mag
        assign w_sgn[gi] = signed_mode & bin_data_in[gi][DATA_WIDTH-1];
        assign w_mag[gi] = w_sgn[gi] ? -bin_data_in[gi] : bin_data_in[gi];
    end
    if (NUM_INPUTS == 1) begin : g_pad
        assign w_mag[1] = '0;
    end
    assign w_neg = ^w_sgn;

    // The active multiplier always sits in r_ops[0]. It is shifted left
    // after each digit, so the next digit is always its top bits.
    assign w_digit      = r_ops[0][DATA_WIDTH-1 -: BITS_PER_CYCLE];
    assign w_acc_next   = (r_acc << BITS_PER_CYCLE) + r_p * PW'(w_digit);
    assign w_last_dig   = (r_dig == DIGW'(DPS - 1));
    assign w_last_stage = (r_j == JW'(NUM_INPUTS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (en && start) w_next = (NUM_INPUTS > 1) ? MUL : FIX;
            MUL:     if (en && w_last_dig && w_last_stage) w_next = FIX;
            FIX:     if (en) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p    <= '0;
            r_acc  <= '0;
            r_out  <= '0;
            r_dig  <= '0;
            r_j    <= '0;
            r_neg  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            for (int unsigned k = 0; k < OPS; k++) begin
                r_ops[k] <= '0;
            end
        end else if (en) begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_p    <= PW'(w_mag[0]);
                        r_acc  <= '0;
                        r_dig  <= '0;
                        r_j    <= JW'(1);
                        r_neg  <= w_neg;
                        r_busy <= 1'b1;
                        for (int unsigned k = 0; k < OPS; k++) begin
                            r_ops[k] <= w_mag[k+1];
                        end
                    end
                end
                MUL: begin
                    r_ops[0] <= r_ops[0] << BITS_PER_CYCLE;
                    if (w_last_dig) begin
                        // End of stage: the partial product becomes the new
                        // multiplicand, and the queue advances to the next
                        // operand.
                        r_p   <= w_acc_next;
                        r_acc <= '0;
                        r_dig <= '0;
                        r_j   <= r_j + JW'(1);
                        for (int unsigned k = 0; k + 1 < OPS; k++) begin
                            r_ops[k] <= r_ops[k+1];
                        end
                    end else begin
                        r_acc <= w_acc_next;
                        r_dig <= r_dig + DIGW'(1);
                    end
                end
                FIX: begin
                    r_out  <= r_neg ? -r_p : r_p;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bin_data_out = r_out;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
